// File: rtl/fft_pkg.sv
// Shared definitions for the FFT front end: sample width, frame size and
// the input-buffer state encoding.
package fft_pkg;

  localparam int DW     = 9;
  localparam int NPTS   = 8;
  localparam int SLOT_W = $clog2(NPTS);

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } state_t;

endpackage

// File: rtl/fft_input_buffer.sv
// Serial-to-parallel buffer: collects 8 complex samples, then presents them
// as one frame to the FFT core and holds them until the core acknowledges.
module fft_input_buffer
  import fft_pkg::*;
#(
  parameter int DW   = fft_pkg::DW,
  parameter int NPTS = fft_pkg::NPTS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DW-1:0]        in_re,
  input  logic [DW-1:0]        in_im,
  input  logic                 in_last,
  output logic [NPTS*DW-1:0]   x_re_flat,
  output logic [NPTS*DW-1:0]   x_im_flat,
  output logic                 frame_valid,
  input  logic                 frame_ack,
  output logic                 frame_err,
  input  logic                 err_clr,
  output logic [SLOT_W-1:0]    fill_cnt
);

  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NPTS - 1);

  state_t        state;
  logic [DW-1:0] slot_re [NPTS];
  logic [DW-1:0] slot_im [NPTS];

  wire xfer = in_valid && in_ready;

  // NOTE: the sample slots are reset along with the control state so that a
  // reset mid-frame can never leak stale samples into a later frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= FILL;
      in_ready    <= 1'b0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      fill_cnt    <= '0;
      for (int k = 0; k < NPTS; k++) begin
        slot_re[k] <= '0;
        slot_im[k] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments throughout, so a later "set" of
      // frame_err in this block overrides the clear on the same edge.
      if (err_clr) frame_err <= 1'b0;

      case (state)
        FILL: begin
          in_ready <= 1'b1;
          if (xfer) begin
            slot_re[fill_cnt] <= in_re;
            slot_im[fill_cnt] <= in_im;
            if (fill_cnt == LAST_SLOT) begin
              state       <= FULL;
              frame_valid <= 1'b1;
              in_ready    <= 1'b0;
              fill_cnt    <= '0;
              if (!in_last) frame_err <= 1'b1;
            end else if (in_last) begin
              // Early last: drop the partial frame and restart at slot 0.
              fill_cnt  <= '0;
              frame_err <= 1'b1;
            end else begin
              fill_cnt <= fill_cnt + SLOT_W'(1);
            end
          end
        end

        FULL: begin
          if (frame_ack) begin
            state       <= FILL;
            frame_valid <= 1'b0;
            in_ready    <= 1'b1;
          end
        end

        default: state <= FILL;
      endcase
    end
  end

  always_comb begin
    x_re_flat = '0;
    x_im_flat = '0;
    for (int k = 0; k < NPTS; k++) begin
      x_re_flat[k*DW +: DW] = slot_re[k];
      x_im_flat[k*DW +: DW] = slot_im[k];
    end
  end

endmodule

// File: tb/tb_fft_input_buffer.sv
// Self-checking bench for fft_input_buffer: a reference model tracks slots,
// counter and error flag; completed frames go through a scoreboard queue.
module tb_fft_input_buffer;
  import fft_pkg::*;

  localparam int FW = NPTS * DW;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid, in_ready, in_last;
  logic [DW-1:0]   in_re, in_im;
  logic [FW-1:0]   x_re_flat, x_im_flat;
  logic            frame_valid, frame_ack, frame_err, err_clr;
  logic [SLOT_W-1:0] fill_cnt;

  fft_input_buffer dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_re      (in_re),
    .in_im      (in_im),
    .in_last    (in_last),
    .x_re_flat  (x_re_flat),
    .x_im_flat  (x_im_flat),
    .frame_valid(frame_valid),
    .frame_ack  (frame_ack),
    .frame_err  (frame_err),
    .err_clr    (err_clr),
    .fill_cnt   (fill_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [FW-1:0] re;
    logic [FW-1:0] im;
  } frame_t;

  frame_t        sb[$];
  logic [FW-1:0] m_re, m_im;
  int            m_cnt;
  bit            m_err;
  int            n_checks = 0;
  int            n_errors = 0;

  task automatic check(input string tag, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    m_re  = '0;
    m_im  = '0;
    m_cnt = 0;
    m_err = 1'b0;
  endtask

  // One transfer; the bench expects in_ready=1 beforehand.
  task automatic xfer(input int re, input int im, input bit last, input bit clr = 1'b0);
    bit done;
    frame_t f;
    check("in_ready_pre", FW'(in_ready), FW'(1));
    in_valid = 1'b1;
    in_re    = DW'(re);
    in_im    = DW'(im);
    in_last  = last;
    err_clr  = clr;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    err_clr  = 1'b0;

    m_re[m_cnt*DW +: DW] = DW'(re);
    m_im[m_cnt*DW +: DW] = DW'(im);
    if (clr) m_err = 1'b0;
    done = 1'b0;
    if (m_cnt == NPTS - 1) begin
      done  = 1'b1;
      m_cnt = 0;
      if (!last) m_err = 1'b1;
    end else if (last) begin
      m_cnt = 0;
      m_err = 1'b1;
    end else begin
      m_cnt++;
    end
    if (done) begin
      f.re = m_re;
      f.im = m_im;
      sb.push_back(f);
    end

    check("fill_cnt", FW'(fill_cnt), FW'(m_cnt));
    check("frame_err", FW'(frame_err), FW'(m_err));
    check("frame_valid", FW'(frame_valid), FW'(done));
    check("in_ready", FW'(in_ready), FW'(!done));
    if (frame_valid) begin
      if (sb.size() == 0) begin
        check("sb_unexpected_frame", FW'(1), FW'(0));
      end else begin
        f = sb.pop_front();
        check("frame_re", x_re_flat, f.re);
        check("frame_im", x_im_flat, f.im);
      end
    end else begin
      check("slots_re", x_re_flat, m_re);
      check("slots_im", x_im_flat, m_im);
    end
  endtask

  task automatic hold_full(input int n);
    in_valid = 1'b1;
    in_re    = 9'h0FF;
    in_im    = 9'h0FF;
    repeat (n) begin
      @(posedge clk); #1;
      check("hold_valid", FW'(frame_valid), FW'(1));
      check("hold_ready", FW'(in_ready), FW'(0));
      check("hold_re", x_re_flat, m_re);
      check("hold_im", x_im_flat, m_im);
      check("hold_cnt", FW'(fill_cnt), FW'(0));
    end
    in_valid = 1'b0;
  endtask

  task automatic ack();
    frame_ack = 1'b1;
    @(posedge clk); #1;
    frame_ack = 1'b0;
    check("ack_valid", FW'(frame_valid), FW'(0));
    check("ack_ready", FW'(in_ready), FW'(1));
    check("ack_err", FW'(frame_err), FW'(m_err));
  endtask

  task automatic clear_err();
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    m_err   = 1'b0;
    check("err_clr", FW'(frame_err), FW'(0));
  endtask

  // Asynchronous reset applied between edges, then released.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    check("rst_re", x_re_flat, '0);
    check("rst_im", x_im_flat, '0);
    check("rst_valid", FW'(frame_valid), FW'(0));
    check("rst_ready", FW'(in_ready), FW'(0));
    check("rst_err", FW'(frame_err), FW'(0));
    check("rst_cnt", FW'(fill_cnt), FW'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    check("rel_ready_low", FW'(in_ready), FW'(0));
    @(posedge clk); #1;
    check("rel_ready_high", FW'(in_ready), FW'(1));
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_re = '0; in_im = '0;
    frame_ack = 1'b0; err_clr = 1'b0;
    model_reset();
    #2;
    do_reset();

    // Ramp frame: re=k, im=-k, then a long un-acked FULL period.
    for (int k = 0; k < NPTS; k++) xfer(k, -k, k == NPTS - 1);
    hold_full(20);
    ack();

    // Ack while filling has no effect.
    xfer(11, 12, 1'b0);
    frame_ack = 1'b1;
    @(posedge clk); #1;
    frame_ack = 1'b0;
    check("ack_in_fill_cnt", FW'(fill_cnt), FW'(m_cnt));
    check("ack_in_fill_valid", FW'(frame_valid), FW'(0));

    // Early last on the 3rd sample of a new frame, then a clean frame.
    do_reset();
    xfer(21, 22, 1'b0);
    xfer(23, 24, 1'b0);
    xfer(25, 26, 1'b1);
    for (int k = 0; k < NPTS; k++) xfer(40 + k, -40 - k, k == NPTS - 1);
    ack();
    clear_err();

    // Missing last on the 8th sample; set-wins test on the same kind of edge.
    for (int k = 0; k < NPTS; k++) xfer(60 + k, 70 + k, 1'b0);
    ack();
    clear_err();
    for (int k = 0; k < NPTS; k++) xfer(80 + k, 90 + k, 1'b0, k == NPTS - 1);
    ack();
    clear_err();

    // Reset after 5 transfers discards the partial frame.
    for (int k = 0; k < 5; k++) xfer(100 + k, 110 + k, 1'b0);
    do_reset();
    for (int k = 0; k < NPTS; k++) xfer(120 + k, -120 - k, k == NPTS - 1);
    ack();

    // Extreme values in every slot.
    for (int k = 0; k < NPTS; k++) xfer(-256, 255, k == NPTS - 1);
    check("extreme_re_slot0", FW'(x_re_flat[DW-1:0]), FW'(9'h100));
    check("extreme_im_slot7", FW'(x_im_flat[FW-1 -: DW]), FW'(9'h0FF));
    ack();

    check("sb_empty", FW'(sb.size()), FW'(0));
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/fft_input_buffer.md
FFT_INPUT_BUFFER -- requirements
Module: fft_input_buffer

Interface
REQ-001 Parameters SHALL be, one per line:
- DW, 9, sample component width (signed two's complement).
- NPTS, 8, points per frame; fixed at 8, so the slot index is 3 bits.
REQ-002 Ports SHALL be, one per line:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  upstream sample valid.
- in_ready  out  1  block can accept a sample.
- in_re  in  DW  sample real part, signed.
- in_im  in  DW  sample imaginary part, signed.
- in_last  in  1  marks the 8th sample of a frame.
- x_re_flat  out  NPTS*DW  parallel real parts; slot k at bits [k*DW +: DW].
- x_im_flat  out  NPTS*DW  parallel imaginary parts; same slicing.
- frame_valid  out  1  full 8-sample frame presented to the FFT.
- frame_ack  in  1  FFT consumer has captured the frame.
- frame_err  out  1  sticky framing error.
- err_clr  in  1  clears frame_err.
- fill_cnt  out  3  index of the next slot to be written.

Function
REQ-003 The block SHALL implement two states:
- FILL: in_ready=1, frame_valid=0.
- FULL: in_ready=0, frame_valid=1.
REQ-004 A transfer SHALL occur on a rising clk edge with in_valid=1 and in_ready=1; no other condition SHALL cause a transfer.
REQ-005 On each transfer, slot fill_cnt of x_re_flat/x_im_flat SHALL load in_re/in_im, and fill_cnt SHALL increment.
REQ-006 A transfer at fill_cnt=7 SHALL, at that same edge, set state FULL, frame_valid=1, in_ready=0, and fill_cnt=0. The parallel frame is therefore valid the cycle after the 8th transfer (latency 1).
REQ-007 In FULL, the x_*_flat outputs SHALL be held stable, and in_valid SHALL be ignored.
REQ-008 In FULL, an edge with frame_ack=1 SHALL return the block to FILL (frame_valid=0, in_ready=1 next cycle).
REQ-009 frame_ack received while in FILL SHALL be ignored.
REQ-010 After return to FILL, x_*_flat SHALL retain the previous frame values until individual slots are overwritten.
REQ-011 A transfer with in_last=1 at fill_cnt<7 (early last) SHALL:
- write the slot;
- reset fill_cnt to 0;
- stay in FILL, discarding the partial frame;
- set frame_err.
REQ-012 A transfer at fill_cnt=7 with in_last=0 SHALL complete the frame normally and set frame_err.
REQ-013 frame_err SHALL remain set until an edge with err_clr=1.
REQ-014 When err_clr=1 and a new error occur on the same edge, frame_err SHALL be 1 (set wins).
REQ-015 Samples SHALL be stored bit-exact, with no scaling, rounding or reordering; bit-reversal is the FFT's responsibility.
REQ-016 in_ready SHALL be a registered output; there SHALL be no combinational path from in_valid or frame_ack to any output.

Reset
REQ-017 While rst=1, the outputs SHALL be asynchronously forced to:
- x_re_flat=0, x_im_flat=0;
- frame_valid=0, in_ready=0, frame_err=0, fill_cnt=0;
- state FILL.
REQ-018 in_ready SHALL rise at the first clk edge after rst deasserts.
REQ-019 Reset asserted mid-fill or in FULL SHALL discard the frame; no partial state SHALL survive.

Structure
REQ-020 Shared package fft_pkg SHALL hold:
- DW;
- NPTS;
- the state enum {FILL, FULL};
- the slot-index width constant.
REQ-021 The block SHALL be a single module with no sub-modules; its flattened outputs SHALL connect directly to the FFT core's x0..x7 inputs through slice assignments in the parent.

Verification
REQ-022 Bench directed scenarios:
- Reset, then stream 8 samples with in_re=k and in_im=-k, in_last on the 8th -> frame_valid=1 one cycle after the 8th transfer; slot k reads re=k, im=-k; in_ready=0.
- Hold frame_ack=0 for 20 cycles with in_valid=1 and in_re=0x0FF -> outputs unchanged and no transfers; then pulse frame_ack -> in_ready=1 next cycle, frame_valid=0.
- in_last on the 3rd sample -> frame_err=1, fill_cnt=0, no frame_valid; next 8 clean samples produce a valid frame, and frame_err stays 1 until err_clr.
- 8th sample without in_last -> frame_valid=1 and frame_err=1; err_clr pulse -> frame_err=0.
- Assert rst after 5 transfers, release, send 8 samples -> frame_valid asserts only after 8 new transfers; stale slots are 0 before being written.
- Extreme values: in_re=-256 (0x100) and in_im=+255 in every slot -> read back bit-exact.
